// File: rtl/adc_sweep_sequencer_if.sv
// Interface bundling the ADC-FSM control link and the averaged-result stream.
//   st_conv   : start-of-conversion to the ADC FSM (sequencer -> ADC)
//   cal       : calibration select to the ADC FSM (sequencer -> ADC)
//   adc_done  : conversion done from the ADC FSM, asynchronous to clk (ADC -> sequencer)
//   result_in : ADC result, stable while adc_done is high (ADC -> sequencer)
//   out_data  : averaged result (sequencer -> consumer)
//   out_idx   : sweep point index of out_data (sequencer -> consumer)
//   out_valid : out_data/out_idx valid (sequencer -> consumer)
//   out_ready : consumer accepts (consumer -> sequencer)
interface adc_sweep_sequencer_if #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned NPTS_W = 11
) ();
    logic              st_conv;
    logic              cal;
    logic              adc_done;
    logic [WIDTH-1:0]  result_in;
    logic [WIDTH-1:0]  out_data;
    logic [NPTS_W-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;

    // Sequencer side
    modport master (
        output st_conv, cal, out_data, out_idx, out_valid,
        input  adc_done, result_in, out_ready
    );

    // ADC FSM / consumer side
    modport slave (
        input  st_conv, cal, out_data, out_idx, out_valid,
        output adc_done, result_in, out_ready
    );
endinterface

// File: rtl/adc_sweep_sequencer.sv
// Sequences a SAR ADC FSM through a measurement sweep: optional calibration
// conversion, then 2^AVG_LOG2 averaged conversions per sweep point, each
// averaged point delivered over a valid/ready handshake.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : begin sweep (accepted in IDLE only)
//   i_abort          : synchronous abort, any state, highest priority
//   i_cal_en         : run a calibration conversion first (sampled with start)
//   i_num_points     : number of sweep points (sampled with start)
//   bus (master)     : ADC control link and averaged-result stream
//   o_busy           : high in any state except IDLE
//   o_done           : one-cycle pulse on normal sweep completion
//   o_timeout_err    : sticky timeout flag, cleared by the next accepted start
module adc_sweep_sequencer #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned NPTS_W    = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_cal_en,
    input  logic [NPTS_W-1:0]     i_num_points,
    adc_sweep_sequencer_if.master bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout_err
);

    localparam int unsigned ACC_W  = WIDTH + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned NAVG   = 1 << AVG_LOG2;
    localparam int unsigned PCNT_W = $clog2(PULSE_LEN + 1);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAL_PULSE, S_CAL_WAIT, S_CONV_PULSE, S_CONV_WAIT, S_OUT, S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_sync1, r_sync2, r_sync3;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_conv_cnt;
    logic [PCNT_W-1:0] r_pulse_cnt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [NPTS_W-1:0] r_pt_idx;
    logic [NPTS_W-1:0] r_num_pts;
    logic              r_st_conv, r_cal, r_out_valid, r_busy, r_done, r_timeout_err;
    logic [WIDTH-1:0]  r_out_data;
    logic [NPTS_W-1:0] r_out_idx;

    logic              w_done_evt, w_pulse_last, w_wait_last, w_conv_last, w_pt_last;
    logic              w_hs, w_accept, w_timeout;
    logic [ACC_W-1:0]  w_acc_sum;
    logic              w_st_conv_nxt, w_cal_nxt, w_out_valid_nxt, w_busy_nxt, w_done_nxt;

    assign w_done_evt   = r_sync2 & ~r_sync3;
    assign w_pulse_last = (r_pulse_cnt == PCNT_W'(PULSE_LEN - 1));
    assign w_wait_last  = (r_wait_cnt == WCNT_W'(TIMEOUT - 1));
    assign w_conv_last  = (r_conv_cnt == CNT_W'(NAVG - 1));
    assign w_pt_last    = (NPTS_W'(r_pt_idx + NPTS_W'(1)) == r_num_pts);
    assign w_hs         = r_out_valid & bus.out_ready;
    assign w_accept     = (r_state == S_IDLE) & i_start & ~i_abort;
    assign w_acc_sum    = r_acc + ACC_W'(bus.result_in);

    // Two-flop synchronizer plus edge-detect stage for the asynchronous adc_done
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.adc_done;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides every other condition
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_num_points == '0) w_state_nxt = S_FINISH;
                        else if (i_cal_en)      w_state_nxt = S_CAL_PULSE;
                        else                    w_state_nxt = S_CONV_PULSE;
                    end
                end
                S_CAL_PULSE:  if (w_pulse_last) w_state_nxt = S_CAL_WAIT;
                S_CAL_WAIT: begin
                    if (w_done_evt) begin
                        w_state_nxt = S_CONV_PULSE;
                    end else if (w_wait_last) begin
                        w_state_nxt = S_IDLE;
                        w_timeout   = 1'b1;
                    end
                end
                S_CONV_PULSE: if (w_pulse_last) w_state_nxt = S_CONV_WAIT;
                S_CONV_WAIT: begin
                    if (w_done_evt) begin
                        w_state_nxt = w_conv_last ? S_OUT : S_CONV_PULSE;
                    end else if (w_wait_last) begin
                        w_state_nxt = S_IDLE;
                        w_timeout   = 1'b1;
                    end
                end
                S_OUT:    if (w_hs) w_state_nxt = w_pt_last ? S_FINISH : S_CONV_PULSE;
                S_FINISH: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the strobes register in step with it
    always_comb begin
        w_st_conv_nxt   = 1'b0;
        w_cal_nxt       = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_st_conv_nxt   = (w_state_nxt == S_CAL_PULSE) | (w_state_nxt == S_CONV_PULSE);
        w_cal_nxt       = (w_state_nxt == S_CAL_PULSE) | (w_state_nxt == S_CAL_WAIT);
        w_out_valid_nxt = (w_state_nxt == S_OUT);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_FINISH);
    end

    // Registered outputs, counters and accumulator
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_st_conv     <= 1'b0;
            r_cal         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_out_data    <= '0;
            r_out_idx     <= '0;
            r_acc         <= '0;
            r_conv_cnt    <= '0;
            r_pulse_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_pt_idx      <= '0;
            r_num_pts     <= '0;
        end else begin
            r_st_conv   <= w_st_conv_nxt;
            r_cal       <= w_cal_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;

            if (w_accept) begin
                r_num_pts     <= i_num_points;
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end

            // Counters restart on every entry to a pulse/wait state
            if ((w_state_nxt == r_state) &&
                ((r_state == S_CAL_PULSE) || (r_state == S_CONV_PULSE)))
                r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
            else
                r_pulse_cnt <= '0;

            if ((w_state_nxt == r_state) &&
                ((r_state == S_CAL_WAIT) || (r_state == S_CONV_WAIT)))
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            else
                r_wait_cnt <= '0;

            if (w_state_nxt == S_IDLE) begin
                r_acc      <= '0;
                r_conv_cnt <= '0;
                r_pt_idx   <= '0;
            end else if ((r_state == S_CONV_WAIT) && w_done_evt) begin
                r_acc      <= w_acc_sum;
                r_conv_cnt <= r_conv_cnt + CNT_W'(1);
            end else if ((r_state == S_OUT) && w_hs) begin
                r_acc      <= '0;
                r_conv_cnt <= '0;
                r_pt_idx   <= r_pt_idx + NPTS_W'(1);
            end

            // Average is taken from the sum including the final conversion
            if ((r_state == S_CONV_WAIT) && (w_state_nxt == S_OUT)) begin
                r_out_data <= WIDTH'(w_acc_sum >> AVG_LOG2);
                r_out_idx  <= r_pt_idx;
            end
        end
    end

    assign bus.st_conv   = r_st_conv;
    assign bus.cal       = r_cal;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc_sweep_sequencer.sv
// Bench for adc_sweep_sequencer: behavioural ADC model, table of sweep
// vectors plus hand-written timeout, abort and 16-sample averaging sequences.
module tb_adc_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, cal_en;
    logic [10:0] num_points;
    logic        busy, done, terr;

    logic        start4, abort4, cal4;
    logic [10:0] np4;
    logic        busy4, done4, terr4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_sweep_sequencer_if #(.WIDTH(10), .NPTS_W(11)) bus ();
    adc_sweep_sequencer_if #(.WIDTH(10), .NPTS_W(11)) bus4 ();

    adc_sweep_sequencer #(.WIDTH(10), .AVG_LOG2(2), .PULSE_LEN(2), .TIMEOUT(64), .NPTS_W(11)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_cal_en(cal_en),
        .i_num_points(num_points), .bus(bus), .o_busy(busy), .o_done(done), .o_timeout_err(terr)
    );

    adc_sweep_sequencer #(.WIDTH(10), .AVG_LOG2(4), .PULSE_LEN(2), .TIMEOUT(64), .NPTS_W(11)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_abort(abort4), .i_cal_en(cal4),
        .i_num_points(np4), .bus(bus4), .o_busy(busy4), .o_done(done4), .o_timeout_err(terr4)
    );

    // ADC model: conversion completes a few cycles after st_conv falls,
    // adc_done then stays high for three cycles.
    int m_en = 1, m_base = 0, m_ramp = 0, m_cal_val = 999, m_epoch = 0;
    int m_seen_epoch, m_hold, m_lat, m_conv_n;
    bit m_prev_st, m_cal_seen, m_is_cal;

    always @(negedge clk) begin
        if (rst) begin
            bus.adc_done = 1'b0; bus.result_in = '0;
            m_hold = 0; m_lat = 0; m_conv_n = 0; m_seen_epoch = 0;
            m_prev_st = 1'b0; m_cal_seen = 1'b0; m_is_cal = 1'b0;
        end else begin
            if (m_seen_epoch != m_epoch) begin m_seen_epoch = m_epoch; m_conv_n = 0; end
            if (m_hold > 0) begin m_hold--; if (m_hold == 0) bus.adc_done = 1'b0; end
            if (m_prev_st && !bus.st_conv && m_en != 0) begin m_lat = 4; m_is_cal = m_cal_seen; end
            if (m_lat > 0) begin
                m_lat--;
                if (m_lat == 0) begin
                    if (m_is_cal) bus.result_in = 10'(m_cal_val);
                    else begin
                        bus.result_in = 10'(m_base + ((m_ramp != 0) ? (m_conv_n % 4) : 0));
                        m_conv_n++;
                    end
                    bus.adc_done = 1'b1; m_hold = 3;
                end
            end
            if (bus.st_conv) m_cal_seen = bus.cal;
            m_prev_st = bus.st_conv;
        end
    end

    // Second model for the 16-sample instance: always full scale
    int  m4_hold, m4_lat;
    bit  m4_prev;
    always @(negedge clk) begin
        if (rst) begin
            bus4.adc_done = 1'b0; bus4.result_in = '0; m4_hold = 0; m4_lat = 0; m4_prev = 1'b0;
        end else begin
            if (m4_hold > 0) begin m4_hold--; if (m4_hold == 0) bus4.adc_done = 1'b0; end
            if (m4_prev && !bus4.st_conv) m4_lat = 4;
            if (m4_lat > 0) begin
                m4_lat--;
                if (m4_lat == 0) begin bus4.result_in = 10'd1023; bus4.adc_done = 1'b1; m4_hold = 3; end
            end
            m4_prev = bus4.st_conv;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-sweep observations
    int s_pulses, s_cal_pulses, s_cal_late, s_width_err, s_stall_err, s_resume_err;
    int s_done, s_fall_cyc, s_end_cyc, s_abort_ok, s_terr_after_start, got_n;
    int got_d[16];
    int got_i[16];

    task automatic run_sweep(input int np, input int ce, input int stall, input int abort_outs);
        int   cyc, width, falls, stall_left;
        bit   prev_st, prev_valid, hs_prev, hs, aborting, aborted;
        int   held_d, held_i;
        s_pulses = 0; s_cal_pulses = 0; s_cal_late = 0; s_width_err = 0; s_stall_err = 0;
        s_resume_err = 0; s_done = 0; s_fall_cyc = 0; s_end_cyc = -1; s_abort_ok = 0; got_n = 0;
        m_epoch++;
        num_points = 11'(np); cal_en = (ce != 0); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_terr_after_start = int'(terr);
        cyc = 0; width = 0; falls = 0; stall_left = stall; held_d = 0; held_i = 0;
        prev_st = 1'b0; prev_valid = 1'b0; hs_prev = 1'b0; aborting = 1'b0; aborted = 1'b0;
        while (cyc < 4000) begin
            if (aborting) begin
                abort = 1'b0; aborting = 1'b0;
                s_abort_ok = int'(!bus.st_conv && !bus.cal && !bus.out_valid && !busy && !done);
            end
            if (bus.st_conv && !prev_st) begin
                s_pulses++; width = 0;
                if (bus.cal) s_cal_pulses++;
            end
            if (bus.st_conv) width++;
            if (!bus.st_conv && prev_st) begin
                if (width != 2) s_width_err++;
                s_fall_cyc = cyc;
                if (got_n == abort_outs) falls++;
            end
            if (bus.cal && s_pulses >= 2) s_cal_late++;
            if (done) s_done++;
            if (hs_prev && got_n < np && bus.st_conv !== 1'b1) s_resume_err++;
            hs = 1'b0;
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    held_d = int'(bus.out_data); held_i = int'(bus.out_idx); stall_left = stall;
                end else if (int'(bus.out_data) != held_d || int'(bus.out_idx) != held_i) begin
                    s_stall_err++;
                end
                if (bus.st_conv) s_stall_err++;
                if (stall_left > 0) begin bus.out_ready = 1'b0; stall_left--; end
                else bus.out_ready = 1'b1;
                if (bus.out_ready) begin
                    if (got_n < 16) begin got_d[got_n] = int'(bus.out_data); got_i[got_n] = int'(bus.out_idx); end
                    got_n++; hs = 1'b1;
                end
            end else begin
                bus.out_ready = 1'b0;
            end
            hs_prev = hs; prev_st = bus.st_conv; prev_valid = bus.out_valid;
            if (abort_outs > 0 && got_n == abort_outs && falls == 3 && !aborted) begin
                abort = 1'b1; aborting = 1'b1; aborted = 1'b1;
            end
            if (!busy && !aborting) begin s_end_cyc = cyc; break; end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (s_end_cyc < 0) check("sweep_cycle_budget", 0, 1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int np; int ce; int base; int ramp; int stall; int exp_data; int exp_pulses;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int pulses4, cyc4, seen4, d4, i4, done4_seen;
        bit prev4;
        vecs[0] = '{np: 1, ce: 0, base: 100,  ramp: 1, stall: 0,  exp_data: 101,  exp_pulses: 4};
        vecs[1] = '{np: 2, ce: 1, base: 512,  ramp: 0, stall: 0,  exp_data: 512,  exp_pulses: 9};
        vecs[2] = '{np: 3, ce: 0, base: 1023, ramp: 0, stall: 0,  exp_data: 1023, exp_pulses: 12};
        vecs[3] = '{np: 1, ce: 0, base: 200,  ramp: 1, stall: 0,  exp_data: 201,  exp_pulses: 4};
        vecs[4] = '{np: 2, ce: 0, base: 7,    ramp: 1, stall: 20, exp_data: 8,    exp_pulses: 8};
        vecs[5] = '{np: 0, ce: 0, base: 0,    ramp: 0, stall: 0,  exp_data: 0,    exp_pulses: 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cal_en = 1'b0; num_points = '0;
        start4 = 1'b0; abort4 = 1'b0; cal4 = 1'b0; np4 = 11'd1;
        bus.out_ready = 1'b0; bus4.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout_err", int'(terr), 0);
        check("rst_st_conv", int'(bus.st_conv), 0);
        check("rst_cal", int'(bus.cal), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            m_en = 1; m_base = vecs[v].base; m_ramp = vecs[v].ramp; m_cal_val = 999;
            run_sweep(vecs[v].np, vecs[v].ce, vecs[v].stall, 0);
            check($sformatf("v%0d_n_out", v), got_n, vecs[v].np);
            for (int i = 0; i < got_n && i < 16; i++) begin
                check($sformatf("v%0d_data%0d", v, i), got_d[i], vecs[v].exp_data);
                check($sformatf("v%0d_idx%0d", v, i), got_i[i], i);
            end
            check($sformatf("v%0d_pulses", v), s_pulses, vecs[v].exp_pulses);
            check($sformatf("v%0d_cal_pulses", v), s_cal_pulses, vecs[v].ce);
            check($sformatf("v%0d_cal_late", v), s_cal_late, 0);
            check($sformatf("v%0d_pulse_width", v), s_width_err, 0);
            check($sformatf("v%0d_stall_hold", v), s_stall_err, 0);
            check($sformatf("v%0d_resume", v), s_resume_err, 0);
            check($sformatf("v%0d_done_cycles", v), s_done, 1);
            check($sformatf("v%0d_timeout_err", v), int'(terr), 0);
        end

        // No adc_done at all: timeout after 64 wait cycles, no done pulse
        m_en = 0;
        run_sweep(1, 0, 0, 0);
        check("to_flag", int'(terr), 1);
        check("to_busy", int'(busy), 0);
        check("to_done", s_done, 0);
        check("to_pulses", s_pulses, 1);
        check("to_wait_cycles", s_end_cyc - s_fall_cyc, 64);
        m_en = 1; m_base = 55; m_ramp = 0;
        run_sweep(1, 0, 0, 0);
        check("to_cleared_by_start", s_terr_after_start, 0);
        check("to_recover_data", got_d[0], 55);
        check("to_recover_done", s_done, 1);

        // Abort in the third conversion wait of point 3 of 5
        m_base = 300;
        run_sweep(5, 0, 0, 3);
        check("ab_n_out", got_n, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ab_idx%0d", i), got_i[i], i);
            check($sformatf("ab_data%0d", i), got_d[i], 300);
        end
        check("ab_state_cleared", s_abort_ok, 1);
        check("ab_no_done", s_done, 0);
        m_base = 40;
        run_sweep(2, 0, 0, 0);
        check("ab2_n_out", got_n, 2);
        check("ab2_data0", got_d[0], 40);
        check("ab2_idx0", got_i[0], 0);
        check("ab2_data1", got_d[1], 40);
        check("ab2_idx1", got_i[1], 1);
        check("ab2_done", s_done, 1);

        // 16-sample averaging of full-scale results
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        pulses4 = 0; cyc4 = 0; seen4 = 0; d4 = 0; i4 = 0; prev4 = 1'b0; done4_seen = 0;
        while (cyc4 < 3000 && busy4) begin
            if (bus4.st_conv && !prev4 && seen4 == 0) pulses4++;
            prev4 = bus4.st_conv;
            if (bus4.out_valid && seen4 == 0) begin
                seen4 = 1; d4 = int'(bus4.out_data); i4 = int'(bus4.out_idx);
            end
            if (done4) done4_seen++;
            @(posedge clk); #1;
            cyc4++;
        end
        check("avg16_seen", seen4, 1);
        check("avg16_data", d4, 1023);
        check("avg16_idx", i4, 0);
        check("avg16_pulses", pulses4, 16);
        check("avg16_done", done4_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
